store_buffer_be: RTL

- Parametrised store path placed between the MEM stage and the data bus/bridge.
- Converts sb/sh/sw (and sd when DATA_W=64) into lane-shifted write data plus byte enables, and flags misaligned stores.
- Queues accepted stores in a DEPTH-entry FIFO and drains it to the bus with a valid/ready handshake.
- Also queues interrupt-acknowledge writes and reports load/store address hazards so the pipeline can stall loads.

---
 rtl/store_pkg.sv | 22 ++
 rtl/be_lane_gen.sv | 56 +++++
 rtl/store_buffer_be.sv | 129 ++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared store-path definitions: opcodes, interrupt-ack address, log2 helper.
package store_pkg;

  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_SB   = 3'd1;
  localparam logic [2:0] ST_SH   = 3'd2;
  localparam logic [2:0] ST_SW   = 3'd3;
  localparam logic [2:0] ST_SD   = 3'd4;

  localparam logic [31:0] INT_ACK_ADDR_DEF = 32'h0000_7f20;

  // Ceiling log2 usable in constant expressions (returns 0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/be_lane_gen.sv
// Store lane formation: opcode + byte offset + raw data -> byte enables,
// lane-shifted write data and an alignment/illegal-op flag.
module be_lane_gen
  import store_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned LANES  = DATA_W / 8,
  localparam int unsigned OFF_W  = clog2(LANES)
) (
  input  logic              i_valid,
  input  logic [2:0]        i_op,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_data,
  output logic [LANES-1:0]  o_byteen,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_exc
);

  logic [OFF_W+2:0] w_shamt;
  logic             w_bad;

  assign w_shamt = {i_off, 3'b000};

  // Decode opcode into lane mask, shifted data and misalignment.
  always_comb begin
    o_byteen = '0;
    o_wdata  = '0;
    w_bad    = 1'b0;
    case (i_op)
      ST_NONE: ;
      ST_SB: begin
        o_byteen = LANES'(1) << i_off;
        o_wdata  = DATA_W'(i_data[7:0]) << w_shamt;
      end
      ST_SH: begin
        o_byteen = LANES'(3) << i_off;
        o_wdata  = DATA_W'(i_data[15:0]) << w_shamt;
        w_bad    = i_off[0];
      end
      ST_SW: begin
        o_byteen = LANES'(4'hF) << i_off;
        o_wdata  = DATA_W'(i_data[31:0]) << w_shamt;
        w_bad    = (i_off[1:0] != 2'b00);
      end
      ST_SD: begin
        o_byteen = '1;
        o_wdata  = i_data;
        w_bad    = (DATA_W != 64) || (i_off != '0);
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign o_exc = i_valid & w_bad;

endmodule

// File: rtl/store_buffer_be.sv
// Store buffer between MEM and the data bus: lane formation, DEPTH-entry
// FIFO with interrupt-ack injection, valid/ready drain and load hazard check.
module store_buffer_be
  import store_pkg::*;
#(
  parameter  int unsigned       DATA_W       = 32,
  parameter  int unsigned       ADDR_W       = 32,
  parameter  int unsigned       DEPTH        = 4,
  parameter  logic [ADDR_W-1:0] INT_ACK_ADDR = ADDR_W'(INT_ACK_ADDR_DEF),
  localparam int unsigned       LANES        = DATA_W / 8,
  localparam int unsigned       CNT_W        = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_kill,
  input  logic              int_ack,
  output logic              st_ready,
  output logic              st_exc,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LANES-1:0]  bus_byteen,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned OFF_W = clog2(LANES);
  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [ADDR_W-1:0] r_addr_q [DEPTH];
  logic [LANES-1:0]  r_be_q   [DEPTH];
  logic [DATA_W-1:0] r_data_q [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_ack_pend;

  logic [LANES-1:0]  w_byteen;
  logic [DATA_W-1:0] w_wdata;
  logic              w_full;
  logic              w_ack_req;
  logic              w_ack_enq;
  logic              w_st_enq;
  logic              w_enq;
  logic              w_deq;
  logic [ADDR_W-1:0] w_ent_addr;
  logic [LANES-1:0]  w_ent_be;
  logic [DATA_W-1:0] w_ent_data;
  logic              w_unused_ld;

  be_lane_gen #(.DATA_W(DATA_W)) u_lane (
    .i_valid  (st_valid),
    .i_op     (st_op),
    .i_off    (st_addr[OFF_W-1:0]),
    .i_data   (st_data),
    .o_byteen (w_byteen),
    .o_wdata  (w_wdata),
    .o_exc    (st_exc)
  );

  // A pending or freshly pulsed ack owns the enqueue slot; the store waits.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_ack_req  = r_ack_pend | int_ack;
  assign w_ack_enq  = w_ack_req & ~w_full;
  assign st_ready   = ~w_full & ~w_ack_req;
  assign w_st_enq   = st_valid & (st_op != ST_NONE) & ~st_exc & ~st_kill & st_ready;
  assign w_enq      = w_ack_enq | w_st_enq;
  assign w_deq      = bus_valid & bus_ready;

  assign w_ent_addr = w_ack_enq ? {INT_ACK_ADDR[ADDR_W-1:OFF_W], OFF_W'(0)}
                                : {st_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign w_ent_be   = w_ack_enq ? LANES'(1) : w_byteen;
  assign w_ent_data = w_ack_enq ? '0 : w_wdata;

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_q[r_tail] <= w_ent_addr;
      r_be_q[r_tail]   <= w_ent_be;
      r_data_q[r_tail] <= w_ent_data;
    end
  end

  // Pointer, occupancy and ack-pending bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_ack_pend <= 1'b0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      r_ack_pend <= w_ack_req & w_full;
    end
  end

  assign count      = r_count;
  assign bus_valid  = (r_count != '0);
  assign bus_addr   = bus_valid ? r_addr_q[r_head] : '0;
  assign bus_byteen = bus_valid ? r_be_q[r_head]   : '0;
  assign bus_wdata  = bus_valid ? r_data_q[r_head] : '0;

  // Word-granular match of the load against every occupied entry.
  always_comb begin
    logic [PTR_W-1:0] v_rel;
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v_rel = PTR_W'(i) - r_head;
      if ((CNT_W'(v_rel) < r_count) &&
          (r_addr_q[i][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]))
        ld_hazard = 1'b1;
    end
  end

  assign w_unused_ld = ^ld_addr[OFF_W-1:0];

endmodule
